// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU core memory-port arbiter.
// Widths here are the defaults for the request bundle.
package gpu_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_TAG_W  = 8;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;
    localparam int SRC_BIT    = MEM_TAG_W;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                  rw;
        logic [MEM_BE_W-1:0]   byteen;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W:0]    tag;
    } mem_req_t;

endpackage

// File: rtl/gpu_rr_arb2.sv
// Two-way round-robin arbiter; the grant is frozen while the
// downstream port stalls a presented request (hold_i).
module gpu_rr_arb2
    import gpu_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       hold_i,
    input  logic       ack_i,
    output logic [1:0] grant_o
);

    arb_state_e r_state;
    src_e       r_last;
    src_e       r_lock_src;
    src_e       w_pick;
    src_e       w_gsrc;
    logic       w_any;

    assign w_any = |req_i;

    // On a tie the source that did not win last time goes first.
    always_comb begin
        w_pick = SRC_INSTR;
        if (req_i == 2'b11)
            w_pick = (r_last == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        else if (req_i[1])
            w_pick = SRC_DATA;
    end

    assign w_gsrc = (r_state == LOCK) ? r_lock_src : w_pick;

    always_comb begin
        grant_o = 2'b00;
        if (r_state == LOCK || w_any)
            grant_o = (w_gsrc == SRC_DATA) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last     <= SRC_DATA;
            r_lock_src <= SRC_INSTR;
        end else begin
            if (ack_i)
                r_last <= w_gsrc;
            case (r_state)
                IDLE: begin
                    if (hold_i) begin
                        r_state    <= LOCK;
                        r_lock_src <= w_pick;
                    end
                end
                LOCK: begin
                    if (ack_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and LSU;
// the tag MSB records the source and steers responses back.
module gpu_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = MEM_ADDR_W,
    parameter int DATA_WIDTH      = MEM_DATA_W,
    parameter int TAG_WIDTH       = MEM_TAG_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ireq_valid_i,
    input  logic [ADDR_WIDTH-1:0]   ireq_addr_i,
    input  logic [TAG_WIDTH-1:0]    ireq_tag_i,
    output logic                    ireq_ready_o,
    output logic                    irsp_valid_o,
    output logic [DATA_WIDTH-1:0]   irsp_data_o,
    output logic [TAG_WIDTH-1:0]    irsp_tag_o,
    input  logic                    irsp_ready_i,
    input  logic                    dreq_valid_i,
    input  logic                    dreq_rw_i,
    input  logic [DATA_WIDTH/8-1:0] dreq_byteen_i,
    input  logic [ADDR_WIDTH-1:0]   dreq_addr_i,
    input  logic [DATA_WIDTH-1:0]   dreq_data_i,
    input  logic [TAG_WIDTH-1:0]    dreq_tag_i,
    output logic                    dreq_ready_o,
    output logic                    drsp_valid_o,
    output logic [DATA_WIDTH-1:0]   drsp_data_o,
    output logic [TAG_WIDTH-1:0]    drsp_tag_o,
    input  logic                    drsp_ready_i,
    output logic                    mreq_valid_o,
    output logic                    mreq_rw_o,
    output logic [DATA_WIDTH/8-1:0] mreq_byteen_o,
    output logic [ADDR_WIDTH-1:0]   mreq_addr_o,
    output logic [DATA_WIDTH-1:0]   mreq_data_o,
    output logic [TAG_WIDTH:0]      mreq_tag_o,
    input  logic                    mreq_ready_i,
    input  logic                    mrsp_valid_i,
    input  logic [DATA_WIDTH-1:0]   mrsp_data_i,
    input  logic [TAG_WIDTH:0]      mrsp_tag_i,
    output logic                    mrsp_ready_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    mem_req_t      w_ireq;
    mem_req_t      w_dreq;
    mem_req_t      w_mreq;
    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_full;
    logic          w_empty;
    logic          w_req_hs;
    logic          w_rsp_hs;
    logic          w_rsp_src;
    logic          w_rsp_live;
    logic [CW-1:0] r_out;
    logic          r_drop;

    assign w_ireq = '{rw: 1'b0, byteen: '1, addr: ireq_addr_i,
                      data: '0, tag: {SRC_INSTR, ireq_tag_i}};
    assign w_dreq = '{rw: dreq_rw_i, byteen: dreq_byteen_i,
                      addr: dreq_addr_i, data: dreq_data_i,
                      tag: {SRC_DATA, dreq_tag_i}};

    assign w_req = {dreq_valid_i, ireq_valid_i};

    gpu_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (w_req),
        .hold_i  (mreq_valid_o & ~mreq_ready_i),
        .ack_i   (w_req_hs),
        .grant_o (w_grant)
    );

    assign w_full  = (r_out == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_out == '0);
    assign w_mreq  = w_grant[1] ? w_dreq : w_ireq;

    assign mreq_valid_o  = (|w_grant) & ~w_full;
    assign mreq_rw_o     = w_mreq.rw;
    assign mreq_byteen_o = w_mreq.byteen;
    assign mreq_addr_o   = w_mreq.addr;
    assign mreq_data_o   = w_mreq.data;
    assign mreq_tag_o    = w_mreq.tag;
    assign w_req_hs      = mreq_valid_o & mreq_ready_i;

    assign ireq_ready_o = w_grant[0] & mreq_ready_i & ~w_full;
    assign dreq_ready_o = w_grant[1] & mreq_ready_i & ~w_full;

    // With nothing outstanding a response is stale (pre-reset): swallow it.
    assign w_rsp_src    = mrsp_tag_i[SRC_BIT];
    assign w_rsp_live   = mrsp_valid_i & ~w_empty;
    assign irsp_valid_o = w_rsp_live & ~w_rsp_src;
    assign drsp_valid_o = w_rsp_live & w_rsp_src;
    assign irsp_data_o  = mrsp_data_i;
    assign drsp_data_o  = mrsp_data_i;
    assign irsp_tag_o   = mrsp_tag_i[TAG_WIDTH-1:0];
    assign drsp_tag_o   = mrsp_tag_i[TAG_WIDTH-1:0];
    assign mrsp_ready_o = w_empty ? mrsp_valid_i
                        : (w_rsp_src ? drsp_ready_i : irsp_ready_i);
    assign w_rsp_hs     = w_rsp_live & mrsp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out  <= '0;
            r_drop <= 1'b1;
        end else begin
            case ({w_req_hs, w_rsp_hs})
                2'b10:   r_out <= r_out + CW'(1);
                2'b01:   r_out <= r_out - CW'(1);
                default: r_out <= r_out;
            endcase
            if (w_req_hs)
                r_drop <= 1'b0;
            assert (!(mrsp_valid_i && w_empty && !r_drop));
        end
    end

endmodule
